// File: rtl/mac_pe_serial_if.sv
// Digit-serial MAC PE bus: operand/partial-sum digits in, result/forwarded-X
// digits out. The PE side uses the slave modport; the feeding side uses master.
interface mac_pe_serial_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 6
);
  logic [CW-1:0] Cin;
  logic [DW-1:0] Xin;
  logic [DW-1:0] Yin;
  logic          Rdy;
  logic [DW-1:0] Xout;
  logic [DW-1:0] Yout;
  logic          Vld;
  logic          Ovf;
  logic          Busy;

  modport master (
    output Cin, Xin, Yin, Rdy,
    input  Xout, Yout, Vld, Ovf, Busy
  );

  modport slave (
    input  Cin, Xin, Yin, Rdy,
    output Xout, Yout, Vld, Ovf, Busy
  );
endinterface

// File: rtl/mac_pe_serial.sv
// Digit-serial multiply-accumulate PE: Yout = Yin + Xin * Cin per frame.
// Digits arrive LSD first after a one-cycle Rdy strobe; results leave LSD
// first framed by Vld, alongside the forwarded X digits.
// Optional build macro MAC_PE_SATURATE_EN: on carry-out the result saturates
// to all ones instead of wrapping. Ovf reports the carry-out in both builds.
module mac_pe_serial #(
  parameter int unsigned DW = 4,
  parameter int unsigned XN = 2,
  parameter int unsigned YN = 4,
  parameter int unsigned CW = 6
) (
  input  logic           clk,
  input  logic           rst,
  mac_pe_serial_if.slave bus
);
  localparam int unsigned XW   = DW * XN;
  localparam int unsigned YW   = DW * YN;
  localparam int unsigned PW   = XW + CW;
  localparam int unsigned SW   = YW + 1;
  localparam int unsigned CNTW = $clog2(YN + 1);

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(YN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   c_q, c_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [YW-1:0]   r_q, r_d;
  logic            ovf_q, ovf_d;

  logic [PW-1:0]   prod;
  logic [SW-1:0]   sum;
  logic            last_out;
  logic            accept;

  // Full-width multiply-add on the captured operands (used only in CALC)
  always_comb begin
    prod = PW'(x_q) * PW'(c_q);
    sum  = SW'(y_q) + SW'(prod);
  end

  // A new frame is taken in IDLE or in the final OUT cycle (back-to-back)
  always_comb begin
    last_out = (state_q == OUT) && (cnt_q == CNT_LAST);
    accept   = bus.Rdy && ((state_q == IDLE) || last_out);
  end

  // Next-state, digit counter and data-register next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, OUT: begin
        if (state_q == OUT) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last_out) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        // Acceptance overrides the OUT->IDLE exit so frames can chain
        if (accept) begin
          c_d           = bus.Cin;
          x_d[DW-1:0]   = bus.Xin;
          y_d[DW-1:0]   = bus.Yin;
          cnt_d         = CNT_ONE;
          state_d       = (YN == 1) ? CALC : LOAD;
        end
      end
      LOAD: begin
        for (int unsigned k = 1; k < YN; k++) begin
          if (cnt_q == CNTW'(k)) y_d[k*DW +: DW] = bus.Yin;
        end
        for (int unsigned k = 1; k < XN; k++) begin
          if (cnt_q == CNTW'(k)) x_d[k*DW +: DW] = bus.Xin;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = CALC;
      end
      CALC: begin
        ovf_d = sum[YW];
`ifdef MAC_PE_SATURATE_EN
        r_d   = sum[YW] ? '1 : sum[YW-1:0];
`else
        r_d   = sum[YW-1:0];
`endif
        cnt_d   = '0;
        state_d = OUT;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and digit counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand, result and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      r_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      x_q   <= x_d;
      y_q   <= y_d;
      r_q   <= r_d;
      ovf_q <= ovf_d;
    end
  end

  // Outputs decoded purely from registered state and data
  always_comb begin
    bus.Xout = '0;
    bus.Yout = '0;
    bus.Vld  = 1'b0;
    bus.Ovf  = 1'b0;
    bus.Busy = !((state_q == IDLE) || last_out);
    if (state_q == OUT) begin
      bus.Vld = (cnt_q == '0);
      bus.Ovf = ovf_q;
      for (int unsigned k = 0; k < YN; k++) begin
        if (cnt_q == CNTW'(k)) bus.Yout = r_q[k*DW +: DW];
      end
      for (int unsigned k = 0; k < XN; k++) begin
        if (cnt_q == CNTW'(k)) bus.Xout = x_q[k*DW +: DW];
      end
    end
  end
endmodule

// File: tb/tb_mac_pe_serial.sv
// Self-checking bench for mac_pe_serial: directed frames with literal
// expectations, then randomized traffic against a frame-level reference model.
module tb_mac_pe_serial;
  localparam int DW = 4;
  localparam int XN = 2;
  localparam int YN = 4;
  localparam int CW = 6;
  localparam int XW = DW * XN;
  localparam int YW = DW * YN;
  localparam int N  = 4096;
`ifdef MAC_PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_pe_serial_if #(.DW(DW), .CW(CW)) bus ();
  mac_pe_serial #(.DW(DW), .XN(XN), .YN(YN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Minimum-depth instance: YN = XN = 1
  mac_pe_serial_if #(.DW(4), .CW(4)) bus1 ();
  mac_pe_serial #(.DW(4), .XN(1), .YN(1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected outputs per cycle, filled by the model
  logic [DW-1:0] ey [N];
  logic [DW-1:0] ex [N];
  logic          ev [N];
  logic          eo [N];
  logic          eb [N];

  // Per-cycle snapshots for literal checks
  logic          db0 [N];
  logic          dv1 [N];
  logic [3:0]    dy1 [N];
  logic [3:0]    dx1 [N];
  logic          do1 [N];
  logic          db1 [N];

  // Model state
  int free_at = 0;
  bit pend    = 1'b0;
  int pend_t, pc, px, py;
  int model_res, model_ovf;

  // DUT result assembly
  int widx = 0;
  int wacc, xacc, wovf;
  int word_q[$];
  int xword_q[$];
  int ovf_q[$];
  int vld_q[$];

  // Min-depth instance stimulus
  logic       r1_rdy = 1'b0;
  logic [3:0] r1_x = '0, r1_y = '0, r1_c = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic finalize();
    int sum;
    int t;
    sum       = py + px * pc;
    model_ovf = (sum >= (1 << YW)) ? 1 : 0;
    model_res = sum % (1 << YW);
    if (SAT && model_ovf == 1) model_res = (1 << YW) - 1;
    for (int k = 0; k < YN; k++) begin
      t     = pend_t + YN + 1 + k;
      ey[t] = DW'(model_res >> (DW * k));
      ex[t] = (k < XN) ? DW'(px >> (DW * k)) : '0;
      ev[t] = (k == 0);
      eo[t] = model_ovf[0];
    end
  endtask

  task automatic model(input logic rdy, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [CW-1:0] c, input logic r);
    int k;
    if (r) begin
      for (int i = cyc + 1; i < N; i++) begin
        ey[i] = '0; ex[i] = '0; ev[i] = 1'b0; eo[i] = 1'b0; eb[i] = 1'b0;
      end
      pend    = 1'b0;
      free_at = cyc + 1;
    end else begin
      if (rdy && cyc >= free_at) begin
        pend    = 1'b1;
        pend_t  = cyc;
        pc      = int'(c);
        px      = 0;
        py      = 0;
        free_at = cyc + 2 * YN;
        for (int i = cyc + 1; i < cyc + 2 * YN; i++) eb[i] = 1'b1;
      end
      if (pend) begin
        k  = cyc - pend_t;
        py = py + (int'(y) << (DW * k));
        if (k < XN) px = px + (int'(x) << (DW * k));
        if (k == YN - 1) begin
          finalize();
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    chk("Yout", 32'(bus.Yout), 32'(ey[cyc]));
    chk("Xout", 32'(bus.Xout), 32'(ex[cyc]));
    chk("Vld",  32'(bus.Vld),  32'(ev[cyc]));
    chk("Ovf",  32'(bus.Ovf),  32'(eo[cyc]));
    chk("Busy", 32'(bus.Busy), 32'(eb[cyc]));
    if (bus.Vld === 1'b1) begin
      vld_q.push_back(cyc);
      widx = 1;
      wacc = int'(bus.Yout);
      xacc = int'(bus.Xout);
      wovf = int'(bus.Ovf);
    end else if (widx > 0 && widx < YN) begin
      wacc = wacc | (int'(bus.Yout) << (DW * widx));
      xacc = xacc | (int'(bus.Xout) << (DW * widx));
      widx++;
    end
    if (widx == YN) begin
      word_q.push_back(wacc);
      xword_q.push_back(xacc);
      ovf_q.push_back(wovf);
      widx = 0;
    end
  endtask

  task automatic step(input logic rdy, input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [CW-1:0] c, input logic r);
    @(negedge clk);
    if (cyc >= 1) compare_cycle();
    db0[cyc] = bus.Busy;
    dv1[cyc] = bus1.Vld;
    dy1[cyc] = bus1.Yout;
    dx1[cyc] = bus1.Xout;
    do1[cyc] = bus1.Ovf;
    db1[cyc] = bus1.Busy;
    rst      = r;
    bus.Rdy  = rdy;
    bus.Xin  = x;
    bus.Yin  = y;
    bus.Cin  = c;
    bus1.Rdy = r1_rdy;
    bus1.Xin = r1_x;
    bus1.Yin = r1_y;
    bus1.Cin = r1_c;
    model(rdy, x, y, c, r);
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), DW'($urandom), CW'($urandom), 1'b0);
  endtask

  task automatic frame(input logic [XW-1:0] xv, input logic [YW-1:0] yv, input logic [CW-1:0] cv,
                       input int spur_k, input int rst_k);
    logic [DW-1:0] xd;
    logic [CW-1:0] cd;
    for (int k = 0; k < YN; k++) begin
      xd = (k < XN) ? xv[k*DW +: DW] : DW'($urandom);
      cd = (k == 0) ? cv : CW'($urandom);
      step((k == 0) || (k == spur_k), xd, yv[k*DW +: DW], cd, k == rst_k);
    end
  endtask

  task automatic clear_obs();
    vld_q.delete();
    word_q.delete();
    xword_q.delete();
    ovf_q.delete();
  endtask

  initial begin
    int t0;
    for (int i = 0; i < N; i++) begin
      ey[i] = '0; ex[i] = '0; ev[i] = 1'b0; eo[i] = 1'b0; eb[i] = 1'b0;
    end
    rst = 1'b1;
    bus.Rdy = 1'b0; bus.Xin = '0; bus.Yin = '0; bus.Cin = '0;
    bus1.Rdy = 1'b0; bus1.Xin = '0; bus1.Yin = '0; bus1.Cin = '0;

    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b1, '0, '0, '0, 1'b1);  // Rdy coincident with rst is ignored

    // Basic frame
    clear_obs();
    t0 = cyc;
    frame(8'hA5, 16'h1234, 6'h2B, -1, -1);
    idle(6);
    chk("basic_model", 32'(model_res), 32'h2DEB);
    chk("basic_nvld", 32'(vld_q.size()), 32'd1);
    chk("basic_vld_cyc", 32'(vld_q[0]), 32'(t0 + 5));
    chk("basic_word", 32'(word_q[0]), 32'h2DEB);
    chk("basic_xword", 32'(xword_q[0]), 32'h00A5);
    chk("basic_ovf", 32'(ovf_q[0]), 32'd0);

    // Overflow
    clear_obs();
    frame(8'hFF, 16'hFFFF, 6'h3F, -1, -1);
    idle(6);
    chk("ovf_model", 32'(model_res), SAT ? 32'hFFFF : 32'h3EC0);
    chk("ovf_word", 32'(word_q[0]), SAT ? 32'hFFFF : 32'h3EC0);
    chk("ovf_flag", 32'(ovf_q[0]), 32'd1);

    // Back-to-back frames
    clear_obs();
    t0 = cyc;
    frame(8'h12, 16'h0345, 6'h07, -1, -1);
    idle(4);
    frame(8'h3C, 16'hABCD, 6'h15, -1, -1);
    idle(6);
    chk("b2b_nvld", 32'(vld_q.size()), 32'd2);
    chk("b2b_vld0", 32'(vld_q[0]), 32'(t0 + 5));
    chk("b2b_vld1", 32'(vld_q[1]), 32'(t0 + 13));
    chk("b2b_word0", 32'(word_q[0]), 32'h03C3);
    chk("b2b_word1", 32'(word_q[1]), 32'hB0B9);
    chk("b2b_busy0", 32'(db0[t0]), 32'd0);
    chk("b2b_busy4", 32'(db0[t0 + 4]), 32'd1);
    chk("b2b_busy8", 32'(db0[t0 + 8]), 32'd0);

    // Spurious Rdy while busy
    clear_obs();
    frame(8'h5A, 16'h0F0F, 6'h11, 3, -1);
    idle(8);
    chk("rej_nvld", 32'(vld_q.size()), 32'd1);
    chk("rej_word", 32'(word_q[0]), 32'h1509);

    // Reset mid-frame, then a fresh frame
    clear_obs();
    t0 = cyc;
    frame(8'h77, 16'h1111, 6'h22, -1, 3);
    idle(1);
    frame(8'h01, 16'h0000, 6'h01, -1, -1);
    idle(6);
    chk("rst_busy", 32'(db0[t0 + 4]), 32'd0);
    chk("rst_nvld", 32'(vld_q.size()), 32'd1);
    chk("rst_vld_cyc", 32'(vld_q[0]), 32'(t0 + 10));
    chk("rst_word", 32'(word_q[0]), 32'h0001);

    // Minimum-depth instance: X=3, Y=2, C=5 -> sum 0x11
    t0 = cyc;
    r1_rdy = 1'b1; r1_x = 4'h3; r1_y = 4'h2; r1_c = 4'h5;
    idle(1);
    r1_rdy = 1'b0; r1_x = '0; r1_y = '0; r1_c = '0;
    idle(3);
    chk("min_vld1", 32'(dv1[t0 + 1]), 32'd0);
    chk("min_busy1", 32'(db1[t0 + 1]), 32'd1);
    chk("min_vld2", 32'(dv1[t0 + 2]), 32'd1);
    chk("min_yout", 32'(dy1[t0 + 2]), SAT ? 32'hF : 32'h1);
    chk("min_xout", 32'(dx1[t0 + 2]), 32'h3);
    chk("min_ovf", 32'(do1[t0 + 2]), 32'd1);
    chk("min_busy2", 32'(db1[t0 + 2]), 32'd0);
    chk("min_vld3", 32'(dv1[t0 + 3]), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, DW'($urandom), DW'($urandom), CW'($urandom),
           $urandom_range(0, 199) == 0);
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
